// File: rtl/sim_uart_monitor.sv
// sim_uart_monitor: oversampling UART receive monitor with FWFT FIFO and sticky error/EOT flags.
// Define SIM_UART_MONITOR_PRINT_EN to echo received characters to the simulator console.
module sim_uart_monitor #(
  parameter int          CLK_HZ     = 50000000,
  parameter int          BAUD       = 115200,
  parameter int          DATA_BITS  = 8,
  parameter int          PARITY     = 0,
  parameter int          STOP_BITS  = 1,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  EOT_CHAR   = 8'h04
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_rx,
  input  logic                            i_clr,
  output logic [DATA_BITS-1:0]            o_data,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [$clog2(FIFO_DEPTH):0]     o_level,
  output logic                            o_frame_err,
  output logic                            o_parity_err,
  output logic                            o_overflow,
  output logic                            o_eot
);
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0]        HALF  = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0]        FULL  = CW'(DIV - 1);
  localparam logic [2:0]           BLAST = 3'(DATA_BITS - 1);
  localparam logic                 SLAST = 1'(STOP_BITS - 1);
  localparam logic [DATA_BITS-1:0] EOT   = EOT_CHAR[DATA_BITS-1:0];

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   sh_q, sh_d;
  logic                   ferr_q, ferr_d, perr_q, perr_d, cm_q, cm_d;
  logic [AW:0]            wr_q, wr_d, rd_q, rd_d;
  logic                   frame_err_q, frame_err_d, parity_err_q, parity_err_d;
  logic                   overflow_q, overflow_d, eot_q, eot_d;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic                   rx_s, tick, par_exp, valid, full, pop, good, push;

  assign rx_s    = sync_q[1];
  assign tick    = cnt_q == '0;
  assign par_exp = ^sh_q ^ (PARITY == 1);

  always_comb begin
    sync_d  = {sync_q[0], i_rx};
    state_d = state_q;
    cnt_d   = tick ? FULL : cnt_q - 1'b1;
    bit_d   = bit_q;
    stop_d  = stop_q;
    sh_d    = sh_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    cm_d    = 1'b0;
    case (state_q)
      IDLE: if (!rx_s) begin
        state_d = START;
        cnt_d   = HALF;
      end
      START: if (tick) begin
        state_d = rx_s ? IDLE : DATA;
        bit_d   = '0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
      end
      DATA: if (tick) begin
        sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
        bit_d = bit_q + 3'd1;
        if (bit_q == BLAST) begin
          state_d = (PARITY != 0) ? PAR : STOP;
          stop_d  = 1'b0;
        end
      end
      PAR: if (tick) begin
        perr_d  = rx_s != par_exp;
        state_d = STOP;
        stop_d  = 1'b0;
      end
      STOP: if (tick) begin
        ferr_d = ferr_q | !rx_s;
        stop_d = stop_q + 1'b1;
        if (stop_q == SLAST) begin
          state_d = IDLE;
          cm_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The frame registers stay intact during the commit cycle, so cm_q alone marks it.
  always_comb begin
    valid        = wr_q != rd_q;
    full         = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    pop          = valid & i_ready;
    good         = cm_q & !ferr_q & !perr_q;
    push         = good & (!full | pop);
    wr_d         = wr_q + {{AW{1'b0}}, push};
    rd_d         = rd_q + {{AW{1'b0}}, pop};
    frame_err_d  = (cm_q & ferr_q) | (frame_err_q & !i_clr);
    parity_err_d = (cm_q & perr_q) | (parity_err_q & !i_clr);
    overflow_d   = (good & full & !pop) | (overflow_q & !i_clr);
    eot_d        = (push & (sh_q == EOT)) | (eot_q & !i_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sync_q       <= 2'b11;
      cnt_q        <= '0;
      bit_q        <= '0;
      stop_q       <= 1'b0;
      sh_q         <= '0;
      ferr_q       <= 1'b0;
      perr_q       <= 1'b0;
      cm_q         <= 1'b0;
      wr_q         <= '0;
      rd_q         <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
      eot_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      stop_q       <= stop_d;
      sh_q         <= sh_d;
      ferr_q       <= ferr_d;
      perr_q       <= perr_d;
      cm_q         <= cm_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overflow_q   <= overflow_d;
      eot_q        <= eot_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= sh_q;
  end

  assign o_valid      = valid;
  assign o_level      = wr_q - rd_q;
  assign o_data       = valid ? mem_q[rd_q[AW-1:0]] : '0;
  assign o_frame_err  = frame_err_q;
  assign o_parity_err = parity_err_q;
  assign o_overflow   = overflow_q;
  assign o_eot        = eot_q;

`ifdef SIM_UART_MONITOR_PRINT_EN
  always @(posedge clk) begin
    if (rst_n) begin
      if (push) $write("%c", sh_q);
      if (eot_d && !eot_q) begin
        $display("EOT received");
        $finish;
      end
    end
  end
`else
`endif
endmodule

// File: tb/tb_sim_uart_monitor.sv
// tb_sim_uart_monitor: directed bench for sim_uart_monitor at DIV = 10 (8N1 and 8E1 instances).
module tb_sim_uart_monitor;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1, rx_p = 1'b1;
  logic       clr = 1'b0, ready = 1'b0;
  logic [7:0] data, data_p;
  logic       valid, valid_p;
  logic [2:0] level, level_p;
  logic       ferr, perr, ovf, eot, ferr_p, perr_p, ovf_p, eot_p;
  int         total = 0, bad = 0;

  always #5 clk = ~clk;

  sim_uart_monitor #(.CLK_HZ(1000000), .BAUD(100000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_rx(rx), .i_clr(clr), .o_data(data), .o_valid(valid),
    .i_ready(ready), .o_level(level), .o_frame_err(ferr), .o_parity_err(perr),
    .o_overflow(ovf), .o_eot(eot));

  sim_uart_monitor #(.CLK_HZ(1000000), .BAUD(100000), .PARITY(2), .FIFO_DEPTH(4)) dut_p (
    .clk(clk), .rst_n(rst_n), .i_rx(rx_p), .i_clr(clr), .o_data(data_p), .o_valid(valid_p),
    .i_ready(ready), .o_level(level_p), .o_frame_err(ferr_p), .o_parity_err(perr_p),
    .o_overflow(ovf_p), .o_eot(eot_p));

  task automatic drive_bit(input logic b, input bit on_p);
    if (on_p) rx_p = b; else rx = b;
    repeat (10) @(negedge clk);
  endtask

  // Frame starts on a negedge; with pop_on_push, i_ready is high only during the push cycle.
  task automatic send(input logic [7:0] d, input bit par_en, input logic par, input logic stop,
                      input bit pop_on_push, input bit on_p);
    drive_bit(1'b0, on_p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], on_p);
    if (par_en) drive_bit(par, on_p);
    if (pop_on_push) begin
      rx = stop;
      repeat (8) @(posedge clk);
      @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      @(negedge clk);
    end else drive_bit(stop, on_p);
    if (on_p) rx_p = 1'b1; else rx = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic pulse_ready;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clr;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({valid, level, data, ferr, perr, ovf, eot} !== 16'h0) begin
      bad++; $display("FAIL reset_main got=%h exp=0", {valid, level, data, ferr, perr, ovf, eot});
    end
    total++;
    if ({valid_p, level_p, data_p, ferr_p, perr_p, ovf_p, eot_p} !== 16'h0) begin
      bad++; $display("FAIL reset_par got=%h exp=0", {valid_p, level_p, data_p, ferr_p, perr_p, ovf_p, eot_p});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic;
    send(8'h41, 0, 0, 1, 0, 0);
    total++;
    if ({valid, data, level} !== {1'b1, 8'h41, 3'd1}) begin
      bad++; $display("FAIL basic_rx got v=%b d=%h l=%0d exp v=1 d=41 l=1", valid, data, level);
    end
    total++;
    if ({ferr, perr, ovf, eot} !== 4'b0) begin
      bad++; $display("FAIL basic_flags got=%b exp=0000", {ferr, perr, ovf, eot});
    end
    repeat (4) @(negedge clk);
    total++;
    if (data !== 8'h41) begin
      bad++; $display("FAIL basic_hold got=%h exp=41", data);
    end
    pulse_ready();
    total++;
    if ({valid, level, data} !== 12'h0) begin
      bad++; $display("FAIL basic_pop got v=%b l=%0d d=%h exp 0", valid, level, data);
    end
    pulse_ready();
    total++;
    if ({valid, level} !== 4'h0) begin
      bad++; $display("FAIL ready_empty got v=%b l=%0d exp 0", valid, level);
    end
  endtask

  task automatic test_glitch;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    total++;
    if ({level, ferr, perr, ovf, eot} !== 7'h0) begin
      bad++; $display("FAIL glitch got l=%0d flags=%b exp 0", level, {ferr, perr, ovf, eot});
    end
    send(8'h5A, 0, 0, 1, 0, 0);
    total++;
    if ({valid, data} !== {1'b1, 8'h5A}) begin
      bad++; $display("FAIL glitch_after got v=%b d=%h exp v=1 d=5a", valid, data);
    end
    pulse_ready();
  endtask

  task automatic test_frame_err;
    send(8'h55, 0, 0, 0, 0, 0);
    repeat (20) @(negedge clk);
    total++;
    if ({level, ferr, perr, ovf, eot} !== {3'd0, 4'b1000}) begin
      bad++; $display("FAIL frame_err got l=%0d flags=%b exp l=0 flags=1000", level, {ferr, perr, ovf, eot});
    end
    pulse_clr();
    total++;
    if (ferr !== 1'b0) begin
      bad++; $display("FAIL frame_clr got=%b exp=0", ferr);
    end
  endtask

  task automatic test_parity;
    send(8'h03, 1, 1, 1, 0, 1);
    total++;
    if ({level_p, perr_p, ferr_p} !== {3'd0, 2'b10}) begin
      bad++; $display("FAIL parity_bad got l=%0d pe=%b fe=%b exp l=0 pe=1 fe=0", level_p, perr_p, ferr_p);
    end
    send(8'h03, 1, 0, 1, 0, 1);
    total++;
    if ({level_p, data_p, perr_p} !== {3'd1, 8'h03, 1'b1}) begin
      bad++; $display("FAIL parity_good got l=%0d d=%h pe=%b exp l=1 d=03 pe=1", level_p, data_p, perr_p);
    end
    pulse_ready();
    pulse_clr();
    total++;
    if ({valid_p, perr_p} !== 2'b00) begin
      bad++; $display("FAIL parity_clr got v=%b pe=%b exp 0 0", valid_p, perr_p);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 0, 0, 1, 0, 0);
    total++;
    if ({level, ovf} !== {3'd4, 1'b1}) begin
      bad++; $display("FAIL overflow got l=%0d ovf=%b exp l=4 ovf=1", level, ovf);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (data !== 8'h10 + 8'(i)) begin
        bad++; $display("FAIL drain%0d got=%h exp=%h", i, data, 8'h10 + 8'(i));
      end
      pulse_ready();
    end
    pulse_clr();
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), 0, 0, 1, 0, 0);
    send(8'h24, 0, 0, 1, 1, 0);
    total++;
    if ({level, ovf} !== {3'd4, 1'b0}) begin
      bad++; $display("FAIL full_pop_push got l=%0d ovf=%b exp l=4 ovf=0", level, ovf);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (data !== 8'h21 + 8'(i)) begin
        bad++; $display("FAIL drain_b%0d got=%h exp=%h", i, data, 8'h21 + 8'(i));
      end
      pulse_ready();
    end
    total++;
    if (valid !== 1'b0) begin
      bad++; $display("FAIL drained got v=%b exp 0", valid);
    end
  endtask

  task automatic test_eot_reset;
    send(8'h04, 0, 0, 1, 0, 0);
    total++;
    if ({eot, level, data} !== {1'b1, 3'd1, 8'h04}) begin
      bad++; $display("FAIL eot got e=%b l=%0d d=%h exp e=1 l=1 d=04", eot, level, data);
    end
    rx = 1'b0;
    repeat (25) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({valid, level, data, ferr, perr, ovf, eot} !== 16'h0) begin
      bad++; $display("FAIL mid_reset got=%h exp=0", {valid, level, data, ferr, perr, ovf, eot});
    end
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    total++;
    if ({valid, level, data, ferr, perr, ovf, eot} !== 16'h0) begin
      bad++; $display("FAIL after_reset got=%h exp=0", {valid, level, data, ferr, perr, ovf, eot});
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_parity();
    test_overflow();
    test_eot_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
